ch_readout_receiver: RTL and testbench

Channel-readout receiver on the SPI_CLK domain. It is the capture end of the per-channel serial readout link (SELECT_REG / INST_READOUT / CNT_SER). For each readout sweep it selects each channel register in turn, pulses the load strobe, and deserializes the 10-bit frame from CNT_SER. Each completed word is presented on a valid/ready interface to the chip-level SPI response logic.

---
 rtl/ch_readout_receiver_pkg.sv | 24 ++
 rtl/ch_readout_receiver_if.sv | 26 ++
 rtl/ch_readout_receiver_shifter.sv | 24 ++
 rtl/ch_readout_receiver.sv | 92 +++++++++
 tb/tb_ch_readout_receiver.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/ch_readout_receiver_pkg.sv
// ch_readout_receiver_pkg: register codes, receiver states and frame constants for the channel readout link
package ch_readout_receiver_pkg;
  localparam int CH_FRAME_BITS = 10;
  typedef enum logic [2:0] {
    RSEL_TRIGCNT = 3'd0,
    RSEL_CA      = 3'd1,
    RSEL_CB      = 3'd2,
    RSEL_CC      = 3'd3,
    RSEL_CD      = 3'd4,
    RSEL_CE      = 3'd5
  } rsel_t;
  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_LOAD,
    S_WAIT,
    S_SHIFT,
    S_PRESENT,
    S_DONE
  } rx_state_t;
  function automatic rsel_t next_sel(input rsel_t s, input logic skip_empty);
    return (skip_empty && s == RSEL_TRIGCNT) ? RSEL_CE : rsel_t'(s + 3'd1);
  endfunction
endpackage

// File: rtl/ch_readout_receiver_if.sv
// ch_readout_receiver_if: sweep control, serial channel link and word handshake bundle
interface ch_readout_receiver_if
  import ch_readout_receiver_pkg::*;
#(
  parameter int FRAME_BITS = CH_FRAME_BITS
);
  logic start;
  logic cnt_ser;
  logic [2:0] select_reg;
  logic inst_readout;
  logic [FRAME_BITS-1:0] word_data;
  logic [2:0] word_sel;
  logic word_last;
  logic word_valid;
  logic word_ready;
  logic busy;
  logic done;
  modport master (
    input start, cnt_ser, word_ready,
    output select_reg, inst_readout, word_data, word_sel, word_last, word_valid, busy, done
  );
  modport slave (
    output start, cnt_ser, word_ready,
    input select_reg, inst_readout, word_data, word_sel, word_last, word_valid, busy, done
  );
endinterface

// File: rtl/ch_readout_receiver_shifter.sv
// ch_readout_shifter: MSB-first deserializer with bit counter and last-bit flag
module ch_readout_shifter #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         ser,
  output logic [W-1:0] data,
  output logic         frame_done
);
  localparam int CW = $clog2(W);
  logic [CW-1:0] cnt;
  assign frame_done = en && cnt == CW'(W - 1);
  // shift one bit per enabled cycle; the counter wraps after the last bit of a frame
  always_ff @(posedge clk)
    if (rst) begin
      data <= '0;
      cnt  <= '0;
    end else if (en) begin
      data <= {data[W-2:0], ser};
      cnt  <= frame_done ? '0 : cnt + CW'(1);
    end
endmodule

// File: rtl/ch_readout_receiver.sv
// ch_readout_receiver: sweeps channel registers and deserializes frames; CH_READOUT_SKIP_EMPTY_EN skips CA..CD when the trigger count is zero
module ch_readout_receiver
  import ch_readout_receiver_pkg::*;
#(
  parameter int FRAME_BITS = CH_FRAME_BITS,
  parameter int LOAD_LAT   = 1
) (
  input logic clk,
  input logic rst,
  ch_readout_receiver_if.master bus
);
`ifdef CH_READOUT_SKIP_EMPTY_EN
  localparam logic SKIP_EMPTY = 1'b1;
`else
  localparam logic SKIP_EMPTY = 1'b0;
`endif
  localparam logic [1:0] WAIT_INIT = 2'(LOAD_LAT > 1 ? LOAD_LAT - 2 : 0);
  rx_state_t state;
  rsel_t sel;
  rsel_t nxt;
  logic [1:0] wcnt;
  logic frame_done;
  assign nxt = next_sel(sel, SKIP_EMPTY && bus.word_data == '0);
  ch_readout_shifter #(.W(FRAME_BITS)) u_shifter (
    .clk(clk),
    .rst(rst),
    .en(state == S_SHIFT),
    .ser(bus.cnt_ser),
    .data(bus.word_data),
    .frame_done(frame_done)
  );
  // sweep sequencer; every output is set on the transition into the state that owns it
  always_ff @(posedge clk)
    if (rst) begin
      state            <= S_IDLE;
      sel              <= RSEL_TRIGCNT;
      wcnt             <= '0;
      bus.select_reg   <= '0;
      bus.inst_readout <= 1'b0;
      bus.word_sel     <= '0;
      bus.word_last    <= 1'b0;
      bus.word_valid   <= 1'b0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
    end else begin
      bus.inst_readout <= 1'b0;
      bus.done         <= 1'b0;
      case (state)
        S_IDLE:
          if (bus.start) begin
            state          <= S_SELECT;
            sel            <= RSEL_TRIGCNT;
            bus.select_reg <= RSEL_TRIGCNT;
            bus.busy       <= 1'b1;
          end
        S_SELECT: begin
          state            <= S_LOAD;
          bus.inst_readout <= 1'b1;
        end
        S_LOAD: begin
          state <= LOAD_LAT == 1 ? S_SHIFT : S_WAIT;
          wcnt  <= WAIT_INIT;
        end
        S_WAIT:
          if (wcnt == '0) state <= S_SHIFT;
          else wcnt <= wcnt - 2'd1;
        S_SHIFT:
          if (frame_done) begin
            state          <= S_PRESENT;
            bus.word_valid <= 1'b1;
            bus.word_sel   <= sel;
            bus.word_last  <= sel == RSEL_CE;
          end
        S_PRESENT:
          if (bus.word_ready) begin
            bus.word_valid <= 1'b0;
            if (bus.word_last) begin
              state    <= S_DONE;
              bus.done <= 1'b1;
            end else begin
              state          <= S_SELECT;
              sel            <= nxt;
              bus.select_reg <= nxt;
            end
          end
        default: begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_ch_readout_receiver.sv
// tb_ch_readout_receiver: scoreboard bench with channel models for LOAD_LAT=1 and LOAD_LAT=3 receivers
module tb_ch_readout_receiver;
  typedef struct {
    logic [9:0] d;
    logic [2:0] s;
    logic       l;
  } word_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int which = 0;
  int t0 = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int widx = 0;
  int stall_idx = 2;
  int stall_left = 0;
  int n0 = 1000;
  int n1 = 1000;
  logic [9:0] f0 = '0;
  logic [9:0] f1 = '0;
  logic [9:0] regs [8];
  word_t q[$];
  logic v, rdy, dn, l;
  logic [9:0] d;
  logic [2:0] s;

  always #5 clk = ~clk;

  ch_readout_receiver_if b0();
  ch_readout_receiver_if b1();

  ch_readout_receiver #(.LOAD_LAT(1)) dut (.clk(clk), .rst(rst), .bus(b0));
  ch_readout_receiver #(.LOAD_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(b1));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic ser_bit(input logic [9:0] f, input int n, input int lat);
    int i;
    i = n - lat;
    return (i >= 0 && i < 10) ? f[9-i] : 1'($urandom);
  endfunction

  function automatic logic [20:0] outs(input int w);
    return w != 0
      ? {b1.select_reg, b1.inst_readout, b1.word_data, b1.word_sel, b1.word_last, b1.word_valid, b1.busy, b1.done}
      : {b0.select_reg, b0.inst_readout, b0.word_data, b0.word_sel, b0.word_last, b0.word_valid, b0.busy, b0.done};
  endfunction

  // channel models, consumer with optional backpressure, and scoreboard compare
  always @(negedge clk) begin
    v  = which != 0 ? b1.word_valid : b0.word_valid;
    d  = which != 0 ? b1.word_data  : b0.word_data;
    s  = which != 0 ? b1.word_sel   : b0.word_sel;
    l  = which != 0 ? b1.word_last  : b0.word_last;
    dn = which != 0 ? b1.done       : b0.done;
    rdy = 1'b1;
    if (!rst && v) begin
      if (widx == stall_idx && stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
      end
      if (q.size() == 0) check("extra_word", 32'(v), 0);
      else begin
        check("word_data", d, q[0].d);
        check("word_sel", s, q[0].s);
        check("word_last", l, q[0].l);
        if (rdy) begin
          void'(q.pop_front());
          widx++;
        end
      end
    end
    b0.word_ready = rdy;
    b1.word_ready = rdy;
    if (!rst && dn) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (b0.inst_readout) begin
      n0 = 0;
      f0 = regs[b0.select_reg];
    end else n0++;
    b0.cnt_ser = ser_bit(f0, n0, 1);
    if (b1.inst_readout) begin
      n1 = 0;
      f1 = regs[b1.select_reg];
    end else n1++;
    b1.cnt_ser = ser_bit(f1, n1, 3);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_start(input int w, input logic val);
    if (w != 0) b1.start = val;
    else b0.start = val;
  endtask

  task automatic set_regs(input logic [9:0] r0, input logic [9:0] r5);
    regs[0] = r0;
    regs[1] = 10'h2A5;
    regs[2] = 10'h001;
    regs[3] = 10'h3FF;
    regs[4] = 10'h155;
    regs[5] = r5;
    regs[6] = 10'h0F0;
    regs[7] = 10'h30F;
  endtask

  task automatic expect_sweep();
    for (int c = 0; c < 6; c++) begin
`ifdef CH_READOUT_SKIP_EMPTY_EN
      if (regs[0] == 10'h000 && c >= 1 && c <= 4) continue;
`endif
      q.push_back('{d: regs[c], s: 3'(c), l: c == 5});
    end
  endtask

  task automatic sweep(input int w, input int stall_n, input int again, input int exp_done);
    int nw;
    which = w;
    stall_left = stall_n;
    widx = 0;
    done_cnt = 0;
    q.delete();
    expect_sweep();
    nw = q.size();
    step();
    set_start(w, 1'b1);
    t0 = cyc;
    step();
    set_start(w, 1'b0);
    check("busy_t1", w != 0 ? b1.busy : b0.busy, 1);
    check("sel_t1", w != 0 ? b1.select_reg : b0.select_reg, 0);
    step();
    check("load_t2", w != 0 ? b1.inst_readout : b0.inst_readout, 1);
    for (int i = 0; i < 400 && done_cnt == 0; i++) begin
      step();
      set_start(w, again != 0 && cyc == t0 + 20);
    end
    check("done_seen", done_cnt, 1);
    check("done_at", done_cyc - t0, exp_done);
    step();
    set_start(w, 1'b0);
    check("busy_after", w != 0 ? b1.busy : b0.busy, 0);
    repeat (again != 0 ? 20 : 1) step();
    check("one_done", done_cnt, 1);
    check("words", widx, nw);
    check("sb_empty", q.size(), 0);
  endtask

  initial begin
    b0.start = 1'b0;
    b1.start = 1'b0;
    set_regs(10'h003, 10'h200);
    rst = 1'b1;
    repeat (3) step();
    check("reset_outs0", outs(0), 0);
    check("reset_outs1", outs(1), 0);
    rst = 1'b0;
    step();
    sweep(0, 0, 0, 79);
    sweep(0, 5, 0, 84);
    which = 0;
    stall_left = 0;
    widx = 0;
    q.delete();
    expect_sweep();
    step();
    b0.start = 1'b1;
    t0 = cyc;
    step();
    b0.start = 1'b0;
    while (cyc < t0 + 45) step();
    rst = 1'b1;
    step();
    check("midshift_rst", outs(0), 0);
    rst = 1'b0;
    q.delete();
    step();
    sweep(0, 0, 0, 79);
    sweep(0, 0, 1, 79);
    set_regs(10'h000, 10'h0C3);
`ifdef CH_READOUT_SKIP_EMPTY_EN
    sweep(0, 0, 0, 27);
`else
    sweep(0, 0, 0, 79);
`endif
    set_regs(10'h003, 10'h200);
    sweep(1, 0, 0, 91);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
